cpu_mc: RTL and testbench
=========================

CPU_MC -- requirements
Module: cpu_mc

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- UART_ADDR, 32'hF600_0000, store address that is routed to the UART port instead of data memory.
- RETIRE_W, 32, width of the retired-instruction counter.

REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- imem_req, out, 1, instruction fetch request.
- imem_addr, out, 32, fetch address (the current PC).
- imem_ready, in, 1, fetch completes this cycle.
- imem_rdata, in, 32, instruction word, valid when imem_ready=1.
- dmem_req, out, 1, data access request.
- dmem_we, out, 1, 1 = store, 0 = load.
- dmem_addr, out, 32, effective address.
- dmem_wdata, out, 32, store data (rs2).
- dmem_alucode, out, 6, access width/sign code; the memory side performs extraction and extension.
- dmem_ready, in, 1, data access completes this cycle.
- dmem_rdata, in, 32, load data, already extended.
- uart_valid, out, 1, byte offered to the UART.
- uart_data, out, 8, rs2[7:0] of the UART store.
- uart_ready, in, 1, UART accepts the byte.
- halted, out, 1, core has stopped.
- retired, out, RETIRE_W, count of completed instructions.

Function
REQ-003 The core SHALL be a multi-cycle RV32I sequencer with states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-004 In FETCH the core SHALL hold imem_req=1 and imem_addr=pc with both stable until imem_ready=1, then latch ir=imem_rdata and move to DECODE on that edge.
REQ-005 DECODE SHALL last exactly one cycle: decode ir and read rs1/rs2 from the register file into operand registers.
REQ-006 EXEC SHALL last exactly one cycle, latching alu_result and nextpc (branch/jump target or pc+4).
- Transition from EXEC: to MEM if is_load or is_store, else to WB.
REQ-007 In MEM, a store with alu_result==UART_ADDR SHALL assert uart_valid=1 with uart_data=rs2[7:0] and hold both until uart_ready=1; dmem_req SHALL stay 0 for that store.
REQ-008 Any other load or store in MEM SHALL hold dmem_req=1 with dmem_addr, dmem_we, dmem_wdata and dmem_alucode stable until dmem_ready=1.
- Load data SHALL be captured on the dmem_ready edge.
- Transition from MEM: to WB on completion of the handshake.
REQ-009 WB SHALL last one cycle and perform, on its edge:
- write rd if reg_we and rd!=0, using load data for loads and alu_result otherwise;
- pc <= nextpc;
- retired += 1, wrapping modulo 2^RETIRE_W;
- next state HALT if is_halt, else FETCH.
REQ-010 Cycle counts with zero-wait memory SHALL be: ALU/branch 4 cycles, load/store 5 cycles; each wait cycle of ready adds one.
REQ-011 HALT SHALL be absorbing (left only by reset).
- halted=1 in HALT.
- No requests, no register writes, retired frozen.
REQ-012 Register x0 SHALL always read 0.
REQ-013 A register written in WB SHALL be visible to the DECODE of the next instruction, with no forwarding required.
REQ-014 ready inputs asserted while the corresponding request is 0 SHALL be ignored.
REQ-015 Requests SHALL never be withdrawn before their ready arrives.

Reset
REQ-016 While rst=1, independent of clk:
- state=FETCH, pc=RESET_PC, retired=0, halted=0;
- imem_req=dmem_req=uart_valid=0;
- every other output=0, except imem_addr which shows RESET_PC.
REQ-017 Reset asserted mid-handshake SHALL drop every request in the same cycle, with no register write and no retire.
REQ-018 After rst deasserts, the first imem_req SHALL assert in the first cycle, with no extra idle cycle.
REQ-019 Register file contents SHALL be cleared to 0 by reset.

Structure
REQ-020 State encoding, alucode values and the aluop type codes SHALL live in the shared package/include alongside the existing alucode definitions.
REQ-021 The FSM SHALL be one sub-module, cpu_mc_ctrl, producing state, request strobes and latch enables.
- Decoder, execute unit and register file SHALL be reused as instances.

Verification
REQ-022 Reset release, zero-wait imem, "addi x1,x0,5" then halt:
- first imem_addr=RESET_PC;
- x1=5 after 4 cycles;
- halted=1 with retired=2.
REQ-023 imem_ready held low 3 cycles on the first fetch:
- imem_req and imem_addr stable throughout;
- instruction completes in 7 cycles.
REQ-024 "sw x1,0(x2)" with x2=UART_ADDR, x1=0x41, uart_ready delayed 2 cycles:
- uart_valid held 3 cycles with uart_data=0x41;
- dmem_req never asserted.
REQ-025 "lw x3,8(x0)", dmem_rdata=0xDEADBEEF, dmem_ready on the second cycle:
- dmem_addr=8, dmem_we=0;
- x3=0xDEADBEEF;
- instruction takes 6 cycles.
REQ-026 rst pulsed during a held dmem_req on a store:
- dmem_req drops asynchronously;
- target register unchanged, retired=0;
- next fetch at RESET_PC.
REQ-027 "beq x0,x0,-4" looping with RETIRE_W=4:
- pc alternates correctly;
- retired wraps 15 -> 0.

Source files
------------

// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the cpu_mc multi-cycle RV32I core: FSM states, instruction
// classes, alucode values, and the decode/ALU/branch helpers used by the top.
package cpu_mc_pkg;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  typedef enum logic [3:0] {
    OP_NOP, OP_ALU, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_HALT
  } optype_e;

  // Bits [2:0] of an alucode are funct3, so memory and branch codes index directly.
  localparam logic [5:0] ALU_ADD  = 6'h00, ALU_SLL  = 6'h01, ALU_SLT  = 6'h02, ALU_SLTU = 6'h03;
  localparam logic [5:0] ALU_XOR  = 6'h04, ALU_SRL  = 6'h05, ALU_OR   = 6'h06, ALU_AND  = 6'h07;
  localparam logic [5:0] ALU_SUB  = 6'h08, ALU_SRA  = 6'h0D;
  localparam logic [5:0] ALU_BEQ  = 6'h10, ALU_BNE  = 6'h11, ALU_BLT  = 6'h14, ALU_BGE  = 6'h15;
  localparam logic [5:0] ALU_BLTU = 6'h16, ALU_BGEU = 6'h17;
  localparam logic [5:0] ALU_LB   = 6'h20, ALU_LH   = 6'h21, ALU_LW   = 6'h22, ALU_LBU  = 6'h24;
  localparam logic [5:0] ALU_LHU  = 6'h25, ALU_SB   = 6'h28, ALU_SH   = 6'h29, ALU_SW   = 6'h2A;

  typedef struct packed {
    optype_e     op;
    logic [5:0]  alucode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_we;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.op      = OP_NOP;
    d.alucode = ALU_ADD;
    d.rd      = ir[11:7];
    d.rs1     = ir[19:15];
    d.rs2     = ir[24:20];
    d.imm     = {{20{ir[31]}}, ir[31:20]};
    d.use_imm = 1'b1;
    d.reg_we  = 1'b0;
    case (ir[6:0])
      7'b0110011: begin
        d.op = OP_ALU; d.use_imm = 1'b0; d.reg_we = 1'b1;
        d.alucode = {2'b00, ir[30], ir[14:12]};
      end
      7'b0010011: begin
        d.op = OP_ALU; d.reg_we = 1'b1;
        d.alucode = {2'b00, (ir[14:12] == 3'b101) & ir[30], ir[14:12]};
      end
      7'b0110111: begin d.op = OP_LUI;   d.reg_we = 1'b1; d.imm = {ir[31:12], 12'b0}; end
      7'b0010111: begin d.op = OP_AUIPC; d.reg_we = 1'b1; d.imm = {ir[31:12], 12'b0}; end
      7'b1101111: begin
        d.op = OP_JAL; d.reg_we = 1'b1;
        d.imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      7'b1100111: begin d.op = OP_JALR; d.reg_we = 1'b1; end
      7'b1100011: begin
        d.op = OP_BRANCH; d.alucode = {3'b010, ir[14:12]};
        d.imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      7'b0000011: begin d.op = OP_LOAD; d.reg_we = 1'b1; d.alucode = {3'b100, ir[14:12]}; end
      7'b0100011: begin
        d.op = OP_STORE; d.alucode = {3'b101, ir[14:12]};
        d.imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      7'b1110011: d.op = OP_HALT;
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] alu(input logic [5:0] code, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    case (code)
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = a + b;
    endcase
    return r;
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_mc_ctrl.sv
// Sequencer for cpu_mc: walks FETCH/DECODE/EXEC/MEM/WB/HALT, drives the bus request
// strobes and the datapath latch enables.
module cpu_mc_ctrl
  import cpu_mc_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic imem_ready_i,
  input  logic dmem_ready_i,
  input  logic uart_ready_i,
  input  logic is_mem_i,
  input  logic is_uart_i,
  input  logic is_halt_i,
  output logic imem_req_o,
  output logic dmem_req_o,
  output logic uart_valid_o,
  output logic halted_o,
  output logic ir_en_o,
  output logic op_en_o,
  output logic ex_en_o,
  output logic ld_en_o,
  output logic wb_en_o
);

  state_e state_q, state_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_d      = state_q;
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    uart_valid_o = 1'b0;
    halted_o     = 1'b0;
    ir_en_o      = 1'b0;
    op_en_o      = 1'b0;
    ex_en_o      = 1'b0;
    ld_en_o      = 1'b0;
    wb_en_o      = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          ir_en_o = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin op_en_o = 1'b1; state_d = S_EXEC; end
      S_EXEC:   begin ex_en_o = 1'b1; state_d = is_mem_i ? S_MEM : S_WB; end
      S_MEM: begin
        if (is_uart_i) begin
          uart_valid_o = 1'b1;
          if (uart_ready_i) state_d = S_WB;
        end else begin
          dmem_req_o = 1'b1;
          ld_en_o    = dmem_ready_i;
          if (dmem_ready_i) state_d = S_WB;
        end
      end
      S_WB:   begin wb_en_o = 1'b1; state_d = is_halt_i ? S_HALT : S_FETCH; end
      S_HALT: halted_o = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Strobes must fall the moment reset rises, not at the next clock.
    if (rst_i) begin
      imem_req_o   = 1'b0;
      dmem_req_o   = 1'b0;
      uart_valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle RV32I core with separate instruction/data handshakes and a
// memory-mapped UART byte port at UART_ADDR.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] UART_ADDR = 32'hF600_0000,
  parameter int          RETIRE_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  output logic [5:0]          dmem_alucode,
  input  logic                dmem_ready,
  input  logic [31:0]         dmem_rdata,
  output logic                uart_valid,
  output logic [7:0]          uart_data,
  input  logic                uart_ready,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  logic [31:0] pc_q, ir_q, rs1_q, rs2_q, res_q, npc_q, ld_q;
  logic [31:0] res_d, npc_d;
  logic [31:0] rf_q [32];
  logic [RETIRE_W-1:0] retired_q;
  dec_t dec;
  logic is_load, is_store, is_uart;
  logic ir_en, op_en, ex_en, ld_en, wb_en;

  assign dec      = decode(ir_q);
  assign is_load  = (dec.op == OP_LOAD);
  assign is_store = (dec.op == OP_STORE);
  assign is_uart  = is_store && (res_q == UART_ADDR);

  cpu_mc_ctrl u_ctrl (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_ready_i (imem_ready),
    .dmem_ready_i (dmem_ready),
    .uart_ready_i (uart_ready),
    .is_mem_i     (is_load | is_store),
    .is_uart_i    (is_uart),
    .is_halt_i    (dec.op == OP_HALT),
    .imem_req_o   (imem_req),
    .dmem_req_o   (dmem_req),
    .uart_valid_o (uart_valid),
    .halted_o     (halted),
    .ir_en_o      (ir_en),
    .op_en_o      (op_en),
    .ex_en_o      (ex_en),
    .ld_en_o      (ld_en),
    .wb_en_o      (wb_en)
  );

  // Loads and stores fall through to the default effective-address computation.
  always_comb begin
    res_d = rs1_q + dec.imm;
    npc_d = pc_q + 32'd4;
    case (dec.op)
      OP_ALU:    res_d = alu(dec.alucode, rs1_q, dec.use_imm ? dec.imm : rs2_q);
      OP_LUI:    res_d = dec.imm;
      OP_AUIPC:  res_d = pc_q + dec.imm;
      OP_JAL:    begin res_d = pc_q + 32'd4; npc_d = pc_q + dec.imm; end
      OP_JALR:   begin res_d = pc_q + 32'd4; npc_d = (rs1_q + dec.imm) & ~32'd1; end
      OP_BRANCH: if (br_taken(dec.alucode[2:0], rs1_q, rs2_q)) npc_d = pc_q + dec.imm;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      res_q     <= '0;
      npc_q     <= '0;
      ld_q      <= '0;
      retired_q <= '0;
    end else begin
      if (ir_en) ir_q <= imem_rdata;
      if (op_en) begin
        rs1_q <= rf_q[dec.rs1];
        rs2_q <= rf_q[dec.rs2];
      end
      if (ex_en) begin
        res_q <= res_d;
        npc_q <= npc_d;
      end
      if (ld_en) ld_q <= dmem_rdata;
      if (wb_en) begin
        pc_q      <= npc_q;
        retired_q <= retired_q + RETIRE_W'(1);
      end
    end
  end

  // NOTE: the register file is cleared by reset, so it is a flop array reset entry by
  // entry rather than an inferred RAM; entry 0 is never written and so always reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && dec.reg_we && (dec.rd != 5'd0)) begin
      rf_q[dec.rd] <= is_load ? ld_q : res_q;
    end
  end

  assign imem_addr    = pc_q;
  assign dmem_we      = dmem_req & is_store;
  assign dmem_addr    = dmem_req ? res_q : '0;
  assign dmem_wdata   = dmem_req ? rs2_q : '0;
  assign dmem_alucode = dmem_req ? dec.alucode : '0;
  assign uart_data    = uart_valid ? rs2_q[7:0] : '0;
  assign retired      = retired_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: reset, fetch waits, UART store, load wait, reset during
// a held store, and a branch loop with a 4-bit retire counter.
module tb_cpu_mc;

  localparam logic [31:0] UART = 32'hF600_0000;
  localparam logic [31:0] HALT = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [5:0]  dmem_alucode;
  logic        uart_valid, uart_ready;
  logic [7:0]  uart_data;
  logic        halted;
  logic [3:0]  retired;

  logic [31:0] prog [64];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          dmem_seen = 1'b0;

  always #5 clk = ~clk;
  assign imem_rdata = prog[imem_addr[7:2]];

  cpu_mc #(.RESET_PC(32'h0), .UART_ADDR(UART), .RETIRE_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_alucode (dmem_alucode),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .uart_valid   (uart_valid),
    .uart_data    (uart_data),
    .uart_ready   (uart_ready),
    .halted       (halted),
    .retired      (retired)
  );

  always @(negedge clk) if (dmem_req) dmem_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_prog(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    for (int i = 0; i < 64; i++) prog[i] = HALT;
    prog[0] = w0; prog[1] = w1; prog[2] = w2; prog[3] = w3;
  endtask

  // Leaves the bench at the first sample point after reset release.
  task automatic start_run(input logic im_rdy, input logic dm_rdy, input logic ua_rdy);
    @(negedge clk);
    rst        = 1'b1;
    imem_ready = im_rdy;
    dmem_ready = dm_rdy;
    uart_ready = ua_rdy;
    dmem_seen  = 1'b0;
    cycles(2);
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (!halted && n < 100) begin @(negedge clk); n++; end
    check(tag, halted, 1'b1);
  endtask

  initial begin
    int n;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    uart_ready = 1'b0;
    dmem_rdata = 32'h0;
    load_prog(32'h0050_0093, HALT, HALT, HALT);

    // Reset state, with ready inputs high to show they are ignored.
    #3;
    imem_ready = 1'b1; dmem_ready = 1'b1; uart_ready = 1'b1;
    #1;
    check("rst imem_req",   imem_req,   1'b0);
    check("rst imem_addr",  imem_addr,  32'h0);
    check("rst dmem_req",   dmem_req,   1'b0);
    check("rst dmem_addr",  dmem_addr,  32'h0);
    check("rst uart_valid", uart_valid, 1'b0);
    check("rst halted",     halted,     1'b0);
    check("rst retired",    retired,    4'd0);

    // addi x1,x0,5 ; ebreak
    start_run(1'b1, 1'b1, 1'b1);
    check("t1 first imem_req",  imem_req,  1'b1);
    check("t1 first imem_addr", imem_addr, 32'h0);
    cycles(3);
    check("t1 x1 at 3 cyc",     dut.rf_q[1], 32'h0);
    cycles(1);
    check("t1 x1 at 4 cyc",     dut.rf_q[1], 32'd5);
    check("t1 pc after addi",   imem_addr,   32'h4);
    check("t1 retired 1",       retired,     4'd1);
    cycles(4);
    check("t1 halted",          halted,      1'b1);
    check("t1 retired 2",       retired,     4'd2);
    cycles(3);
    check("t1 halt absorbing",  halted,      1'b1);
    check("t1 halt no imem",    imem_req,    1'b0);
    check("t1 halt retired",    retired,     4'd2);

    // First fetch waits 3 cycles: addi x1,x0,7 completes in 7.
    load_prog(32'h0070_0093, HALT, HALT, HALT);
    start_run(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2 imem_req w%0d", i),  imem_req,  1'b1);
      check($sformatf("t2 imem_addr w%0d", i), imem_addr, 32'h0);
      cycles(1);
    end
    imem_ready = 1'b1;
    cycles(3);
    check("t2 retired at 6 cyc", retired,     4'd0);
    cycles(1);
    check("t2 x1 at 7 cyc",      dut.rf_q[1], 32'd7);
    check("t2 retired at 7 cyc", retired,     4'd1);

    // lui x2,0xF6000 ; addi x1,x0,0x41 ; sw x1,0(x2) ; ebreak, UART ready after 2 cycles.
    load_prog(32'hF600_0137, 32'h0410_0093, 32'h0011_2023, HALT);
    start_run(1'b1, 1'b1, 1'b0);
    n = 0;
    while (!uart_valid && n < 40) begin @(negedge clk); n++; end
    check("t3 uart latency", n, 11);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t3 uart_valid c%0d", k), uart_valid, 1'b1);
      check($sformatf("t3 uart_data c%0d", k),  uart_data,  8'h41);
      if (k == 2) uart_ready = 1'b1;
      cycles(1);
    end
    check("t3 uart_valid dropped", uart_valid, 1'b0);
    uart_ready = 1'b0;
    wait_halt("t3 halted");
    check("t3 retired",        retired,   4'd4);
    check("t3 dmem never req", dmem_seen, 1'b0);

    // lw x3,8(x0) ; ebreak, dmem ready in the second MEM cycle.
    load_prog(32'h0080_2183, HALT, HALT, HALT);
    dmem_rdata = 32'hDEAD_BEEF;
    start_run(1'b1, 1'b0, 1'b0);
    cycles(3);
    check("t4 dmem_req",     dmem_req,     1'b1);
    check("t4 dmem_addr",    dmem_addr,    32'h8);
    check("t4 dmem_we",      dmem_we,      1'b0);
    check("t4 dmem_alucode", dmem_alucode, 6'h22);
    cycles(1);
    check("t4 dmem_req held",  dmem_req,  1'b1);
    check("t4 dmem_addr held", dmem_addr, 32'h8);
    dmem_ready = 1'b1;
    cycles(1);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    check("t4 dmem_req released", dmem_req,    1'b0);
    check("t4 x3 at 5 cyc",       dut.rf_q[3], 32'h0);
    cycles(1);
    check("t4 x3 at 6 cyc",       dut.rf_q[3], 32'hDEAD_BEEF);
    check("t4 retired",           retired,     4'd1);

    // addi x1,x0,3 ; sw x1,16(x0) held, then reset mid-handshake.
    load_prog(32'h0030_0093, 32'h0010_2823, HALT, HALT);
    start_run(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!dmem_req && n < 40) begin @(negedge clk); n++; end
    check("t5 store latency", n, 7);
    check("t5 dmem_we",       dmem_we,      1'b1);
    check("t5 dmem_addr",     dmem_addr,    32'h10);
    check("t5 dmem_wdata",    dmem_wdata,   32'd3);
    check("t5 dmem_alucode",  dmem_alucode, 6'h2A);
    check("t5 retired pre",   retired,      4'd1);
    cycles(1);
    check("t5 dmem_req held", dmem_req,     1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t5 async dmem_req", dmem_req,    1'b0);
    check("t5 rst retired",    retired,     4'd0);
    check("t5 rst x1",         dut.rf_q[1], 32'h0);
    check("t5 rst imem_req",   imem_req,    1'b0);
    check("t5 rst imem_addr",  imem_addr,   32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5 refetch req",  imem_req,  1'b1);
    check("t5 refetch addr", imem_addr, 32'h0);

    // nop ; beq x0,x0,-4 loop, 4-bit retire counter wraps.
    load_prog(32'h0000_0013, 32'hFE00_0EE3, HALT, HALT);
    start_run(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      cycles(4);
      check($sformatf("t6 pc k%0d", k),      imem_addr, (k % 2 == 1) ? 32'h4 : 32'h0);
      check($sformatf("t6 retired k%0d", k), retired,   32'(k % 16));
    end
    check("t6 not halted", halted, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
